// File: rtl/syscall_pkg.sv
`default_nettype none
// =============================================================================
// Package : syscall_pkg
// Brief   : Syscall codes, bridge FSM states and ASCII helpers for the bridge.
// Rev     : 1.0
// =============================================================================
package syscall_pkg;

    localparam logic [7:0] SYS_EXIT = 8'h01;
    localparam logic [7:0] SYS_PUTC = 8'h03;
    localparam logic [7:0] SYS_PUTF = 8'h04;

    localparam logic [7:0]  C_ASCII_SPACE = 8'h20;
    localparam logic [7:0]  C_ASCII_LF    = 8'h0A;
    localparam int unsigned C_PUTF_LEN    = 10;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } bridge_state_t;

    // Uppercase hex digit: '0'..'9' then 'A'..'F' (0x41 + n - 10 == 0x37 + n).
    function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return 8'h30 + {4'h0, nib};
        end
        return 8'h37 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// =============================================================================
// Module : uart_tx
// Brief  : 8N1 UART transmitter, LSB first, idle high, back-to-back frames.
// Rev    : 1.0
// =============================================================================
module uart_tx #(
    parameter int unsigned DIVISOR = 868
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       txd
);
    localparam int unsigned         C_CNT_W   = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
    localparam logic [C_CNT_W-1:0] C_CNT_MAX = C_CNT_W'(DIVISOR - 1);

    logic               r_busy;
    logic               r_txd;
    logic [C_CNT_W-1:0] r_cnt;
    logic [3:0]         r_bits_left;
    logic [8:0]         r_shift;
    logic               w_bit_end;
    logic               w_frame_end;

    assign w_bit_end   = (r_cnt == '0);
    // Ready during the last stop-bit cycle so the next start bit follows directly.
    assign w_frame_end = r_busy & w_bit_end & (r_bits_left == 4'd0);
    assign ready       = ~r_busy | w_frame_end;
    assign txd         = r_txd;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_busy      <= 1'b0;
            r_txd       <= 1'b1;
            r_cnt       <= '0;
            r_bits_left <= 4'd0;
            r_shift     <= '1;
        end else if (valid && ready) begin
            r_busy      <= 1'b1;
            r_txd       <= 1'b0;
            r_shift     <= {1'b1, data};
            r_bits_left <= 4'd9;
            r_cnt       <= C_CNT_MAX;
        end else if (r_busy) begin
            if (w_bit_end) begin
                if (r_bits_left == 4'd0) begin
                    r_busy <= 1'b0;
                end else begin
                    r_txd       <= r_shift[0];
                    r_shift     <= {1'b1, r_shift[8:1]};
                    r_bits_left <= r_bits_left - 4'd1;
                    r_cnt       <= C_CNT_MAX;
                end
            end else begin
                r_cnt <= r_cnt - 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/syscall_uart_bridge.sv
`default_nettype none
// =============================================================================
// Module : syscall_uart_bridge
// Brief  : Turns tohost exit/putc/putf syscalls into ASCII bytes on a UART TX.
// Rev    : 1.0
// =============================================================================
module syscall_uart_bridge
    import syscall_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ = 100_000_000,
    parameter int unsigned BAUD_RATE  = 115200,
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  tohost,
    input  logic [31:0] syscall1,
    output logic        sys_ready,
    output logic        uart_txd,
    output logic        tx_busy,
    output logic        exited,
    output logic [7:0]  exit_code,
    output logic [7:0]  drop_count
);
    localparam int unsigned         C_DIVISOR = CLOCK_FREQ / BAUD_RATE;
    localparam int unsigned         C_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int unsigned         C_CNT_W   = C_PTR_W + 1;
    localparam logic [C_CNT_W-1:0] C_DEPTH   = C_CNT_W'(FIFO_DEPTH);
    localparam logic [C_CNT_W-1:0] C_RESERVE = C_CNT_W'(C_PUTF_LEN);

    bridge_state_t      r_state;
    bridge_state_t      w_state_next;
    logic [7:0]         r_code;
    logic [31:0]        r_arg;
    logic [3:0]         r_idx;
    logic               r_live;
    logic               r_exited;
    logic [7:0]         r_exit_code;
    logic [7:0]         r_drop_count;
    logic [7:0]         r_mem [FIFO_DEPTH];
    logic [C_PTR_W-1:0] r_wr_ptr;
    logic [C_PTR_W-1:0] r_rd_ptr;
    logic [C_CNT_W-1:0] r_count;

    logic       w_full;
    logic       w_empty;
    logic       w_known;
    logic       w_accept;
    logic       w_drop;
    logic       w_push;
    logic       w_pop;
    logic       w_last;
    logic       w_tx_ready;
    logic [2:0] w_digit;
    logic [3:0] w_nibble;
    logic [7:0] w_byte;

    assign w_full    = (r_count == C_DEPTH);
    assign w_empty   = (r_count == '0);
    assign w_known   = (tohost == SYS_EXIT) | (tohost == SYS_PUTC) | (tohost == SYS_PUTF);
    // r_live holds sys_ready low while reset is applied and for the first cycle after.
    assign sys_ready = r_live & (r_state == IDLE) & ~r_exited & ((C_DEPTH - r_count) >= C_RESERVE);
    assign w_accept  = w_known & sys_ready;
    assign w_drop    = w_known & ~sys_ready & ~r_exited;
    assign w_pop     = ~w_empty & w_tx_ready;
    assign w_last    = (r_code == SYS_PUTF) ? (r_idx == 4'd9) : 1'b1;

    // putf digit k (idx 1..8) is nibble 8-idx, i.e. -idx mod 8.
    assign w_digit  = 3'd0 - r_idx[2:0];
    assign w_nibble = r_arg[{w_digit, 2'b00} +: 4];

    always_comb begin
        w_byte = C_ASCII_LF;
        case (r_code)
            SYS_PUTC: w_byte = r_arg[7:0];
            SYS_PUTF: w_byte = ((r_idx == 4'd0) || (r_idx == 4'd9)) ? C_ASCII_SPACE : hex_ascii(w_nibble);
            default:  w_byte = C_ASCII_LF;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_push       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) w_state_next = EMIT;
            end
            EMIT: begin
                if (!w_full) begin
                    w_push = 1'b1;
                    if (w_last) w_state_next = IDLE;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_live  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_live  <= 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_code <= 8'h00;
            r_arg  <= 32'h0;
            r_idx  <= 4'd0;
        end else if (w_accept) begin
            r_code <= tohost;
            r_arg  <= syscall1;
            r_idx  <= 4'd0;
        end else if (w_push) begin
            r_idx <= r_idx + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_exited     <= 1'b0;
            r_exit_code  <= 8'h00;
            r_drop_count <= 8'h00;
        end else begin
            if (w_accept && (tohost == SYS_EXIT)) begin
                r_exited    <= 1'b1;
                r_exit_code <= syscall1[7:0];
            end
            if (w_drop && (r_drop_count != 8'hFF)) begin
                r_drop_count <= r_drop_count + 8'd1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_push) r_mem[r_wr_ptr] <= w_byte;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    uart_tx #(
        .DIVISOR (C_DIVISOR)
    ) u_uart_tx (
        .clock   (clock),
        .reset_n (reset_n),
        .data    (r_mem[r_rd_ptr]),
        .valid   (~w_empty),
        .ready   (w_tx_ready),
        .txd     (uart_txd)
    );

    assign tx_busy    = ~w_empty | ~w_tx_ready;
    assign exited     = r_exited;
    assign exit_code  = r_exit_code;
    assign drop_count = r_drop_count;

endmodule
`default_nettype wire

// File: tb/tb_syscall_uart_bridge.sv
`default_nettype none
// =============================================================================
// Module : tb_syscall_uart_bridge
// Brief  : Scoreboard bench: reference byte-stream model vs decoded UART frames.
// Rev    : 1.0
// =============================================================================
module tb_syscall_uart_bridge;
    localparam int unsigned C_FCLK     = 120;
    localparam int unsigned C_FBAUD    = 10;
    localparam int unsigned C_DIV      = C_FCLK / C_FBAUD;
    localparam int unsigned C_SLOW_DIV = 868;

    logic        clock    = 1'b0;
    logic        reset_n  = 1'b0;
    logic [7:0]  tohost   = 8'h00;
    logic [31:0] syscall1 = 32'h0;
    logic        sys_ready, uart_txd, tx_busy, exited;
    logic [7:0]  exit_code, drop_count;

    logic [7:0]  s_tohost   = 8'h00;
    logic [31:0] s_syscall1 = 32'h0;
    logic        s_sys_ready, s_txd, s_tx_busy, s_exited;
    logic [7:0]  s_exit_code, s_drop_count;

    always #5 clock = ~clock;

    syscall_uart_bridge #(.CLOCK_FREQ(C_FCLK), .BAUD_RATE(C_FBAUD), .FIFO_DEPTH(16)) u_dut (
        .clock(clock), .reset_n(reset_n), .tohost(tohost), .syscall1(syscall1),
        .sys_ready(sys_ready), .uart_txd(uart_txd), .tx_busy(tx_busy),
        .exited(exited), .exit_code(exit_code), .drop_count(drop_count)
    );

    syscall_uart_bridge u_dut_slow (
        .clock(clock), .reset_n(reset_n), .tohost(s_tohost), .syscall1(s_syscall1),
        .sys_ready(s_sys_ready), .uart_txd(s_txd), .tx_busy(s_tx_busy),
        .exited(s_exited), .exit_code(s_exit_code), .drop_count(s_drop_count)
    );

    int         vectors     = 0;
    int         miscompares = 0;
    logic [7:0] expq[$];
    bit         m_exited    = 1'b0;
    logic [7:0] m_exit_code = 8'h00;
    int         m_drops     = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected console bytes for one accepted syscall.
    function automatic void model_push(input logic [7:0] code, input logic [31:0] arg);
        string hx;
        hx = "0123456789ABCDEF";
        case (code)
            8'h03: expq.push_back(arg[7:0]);
            8'h01: expq.push_back(8'h0A);
            8'h04: begin
                expq.push_back(8'h20);
                for (int i = 7; i >= 0; i--) expq.push_back(hx[int'((arg >> (4 * i)) & 32'hF)]);
                expq.push_back(8'h20);
            end
            default: ;
        endcase
    endfunction

    function automatic void model_reset();
        expq.delete();
        m_exited    = 1'b0;
        m_exit_code = 8'h00;
        m_drops     = 0;
    endfunction

    // Called at a negedge; returns to the caller one negedge later.
    task automatic issue(input logic [7:0] code, input logic [31:0] arg, output bit rdy);
        bit known;
        rdy   = sys_ready;
        known = (code == 8'h01) || (code == 8'h03) || (code == 8'h04);
        if (m_exited) check("ready_while_exited", rdy, 0);
        if (rdy) check("ready_backlog_le7", expq.size() <= 7, 1);
        tohost   = code;
        syscall1 = arg;
        if (known && !m_exited) begin
            if (rdy) begin
                model_push(code, arg);
                if (code == 8'h01) begin
                    m_exited    = 1'b1;
                    m_exit_code = arg[7:0];
                end
            end else if (m_drops < 255) begin
                m_drops++;
            end
        end
        @(negedge clock);
        tohost   = 8'h00;
        syscall1 = $urandom;
        if (known && rdy) check("ready_low_after_accept", sys_ready, 0);
    endtask

    task automatic drain();
        int n, budget;
        n      = 0;
        budget = (expq.size() + 2) * 12 * C_DIV + 100;
        while ((expq.size() != 0 || tx_busy) && n < budget) begin
            @(negedge clock);
            n++;
        end
        check("drain_in_time", n < budget, 1);
        check("tx_busy_idle", tx_busy, 0);
        check("drop_count", drop_count, m_drops);
        check("exited", exited, m_exited);
        check("exit_code", exit_code, m_exit_code);
    endtask

    // UART receiver: decodes frames on the fast DUT and scores them.
    initial begin : monitor
        logic [7:0] b;
        logic       startb, stopb;
        bit         abort;
        forever begin
            @(negedge clock);
            if (reset_n && uart_txd === 1'b0) begin
                abort = 1'b0;
                for (int k = 0; k < C_DIV / 2; k++) begin
                    @(negedge clock);
                    if (!reset_n) abort = 1'b1;
                end
                startb = uart_txd;
                for (int bi = 0; bi < 8; bi++) begin
                    for (int k = 0; k < C_DIV; k++) begin
                        @(negedge clock);
                        if (!reset_n) abort = 1'b1;
                    end
                    b[bi] = uart_txd;
                end
                for (int k = 0; k < C_DIV; k++) begin
                    @(negedge clock);
                    if (!reset_n) abort = 1'b1;
                end
                stopb = uart_txd;
                if (!abort) begin
                    check("start_bit_mid", startb, 0);
                    check("stop_bit", stopb, 1);
                    if (expq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL unexpected_byte: got 0x%0h expected no frame", b);
                    end else begin
                        check("uart_byte", b, expq.pop_front());
                    end
                end
            end
        end
    end

    initial begin : stimulus
        bit          rdy, rdy2;
        int          n, len;
        logic [7:0]  rb;
        logic [31:0] arg;
        logic [7:0]  code;

        // Reset values
        repeat (3) @(negedge clock);
        check("rst_txd", uart_txd, 1);
        check("rst_sys_ready", sys_ready, 0);
        check("rst_tx_busy", tx_busy, 0);
        check("rst_exited", exited, 0);
        check("rst_exit_code", exit_code, 0);
        check("rst_drop_count", drop_count, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("ready_after_reset", sys_ready, 1);

        // 1: putc 0x41 on the default-rate instance
        check("t1_ready", s_sys_ready, 1);
        s_tohost   = 8'h03;
        s_syscall1 = 32'h41;
        n = 0;
        do begin
            @(negedge clock);
            s_tohost = 8'h00;
            n++;
        end while (s_txd !== 1'b0 && n < 20);
        check("t1_start_latency", n, 3);
        check("t1_busy_in_frame", s_tx_busy, 1);
        len = 1;
        while (s_txd === 1'b0 && len < 2000) begin
            @(negedge clock);
            len++;
        end
        len = len - 1;
        check("t1_start_bit_cycles", len, C_SLOW_DIV);
        repeat (C_SLOW_DIV / 2) @(negedge clock);
        rb[0] = s_txd;
        for (int i = 1; i < 8; i++) begin
            repeat (C_SLOW_DIV) @(negedge clock);
            rb[i] = s_txd;
        end
        check("t1_byte", rb, 8'h41);
        repeat (C_SLOW_DIV) @(negedge clock);
        check("t1_stop_bit", s_txd, 1);
        n = 0;
        while (s_tx_busy && n < 2 * C_SLOW_DIV) begin
            @(negedge clock);
            n++;
        end
        check("t1_busy_clears", n <= C_SLOW_DIV, 1);

        // 2: putf 0x3F800000
        issue(8'h04, 32'h3F80_0000, rdy);
        check("t2_accept", rdy, 1);
        drain();

        // 3: back-to-back putf, second one dropped
        issue(8'h04, $urandom, rdy);
        issue(8'h04, $urandom, rdy2);
        check("t3_first_ready", rdy, 1);
        check("t3_second_ready", rdy2, 0);
        drain();
        check("t3_drop_count", drop_count, 1);

        // 4: sys_ready returns once 4 bytes have left the FIFO (3 full frames)
        issue(8'h04, 32'hDEAD_BEEF, rdy);
        check("t4_accept", rdy, 1);
        n = 0;
        while (!sys_ready && n < 60 * C_DIV) begin
            @(negedge clock);
            n++;
        end
        check("t4_ready_not_early", n >= 30 * C_DIV, 1);
        check("t4_ready_not_late", n <= 30 * C_DIV + 4, 1);
        issue(8'h04, 32'h0000_0001, rdy);
        check("t4_second_accept", rdy, 1);
        drain();

        // Random mix of putc/putf with random gaps
        for (int e = 0; e < 30; e++) begin
            code = ($urandom_range(0, 2) == 0) ? 8'h04 : 8'h03;
            arg  = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                n = 0;
                while (!sys_ready && n < 400 * C_DIV) begin
                    @(negedge clock);
                    n++;
                end
                check("rand_ready_timeout", n < 400 * C_DIV, 1);
            end
            issue(code, arg, rdy);
            repeat ($urandom_range(0, 3 * C_DIV)) @(negedge clock);
        end
        drain();

        // 5: exit then putc
        issue(8'h01, 32'h0000_0005, rdy);
        check("t5_accept", rdy, 1);
        issue(8'h03, 32'h0000_0042, rdy);
        drain();
        check("t5_exited", exited, 1);
        check("t5_exit_code", exit_code, 8'h05);
        check("t5_ready_low", sys_ready, 0);

        // 6: reset during data bit 4
        reset_n = 1'b0;
        repeat (2) @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("t6_exited_cleared", exited, 0);
        issue(8'h03, 32'h0000_0000, rdy);
        check("t6_accept_zero", rdy, 1);
        n = 0;
        while (uart_txd !== 1'b0 && n < 10) begin
            @(negedge clock);
            n++;
        end
        check("t6_frame_started", uart_txd, 0);
        repeat (5 * C_DIV + C_DIV / 2) @(negedge clock);
        check("t6_bit4_low", uart_txd, 0);
        #2 reset_n = 1'b0;
        #1;
        check("t6_txd_async", uart_txd, 1);
        check("t6_sys_ready", sys_ready, 0);
        check("t6_tx_busy", tx_busy, 0);
        check("t6_exited", exited, 0);
        check("t6_exit_code", exit_code, 0);
        check("t6_drop_count", drop_count, 0);
        repeat (12 * C_DIV) @(negedge clock);
        model_reset();
        reset_n = 1'b1;
        repeat (2) @(negedge clock);
        check("t6_txd_idle", uart_txd, 1);
        check("t6_busy_idle", tx_busy, 0);
        issue(8'h03, 32'h0000_005A, rdy);
        check("t6_accept", rdy, 1);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
